// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP tx packet RAM write port and send request among N_REQ producers.
// Optional statistics counters are enabled with the UDP_TX_ARB_STATS_EN macro.
module udp_tx_arbiter #(
   parameter int N_REQ       = 3,
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int MAX_PAYLOAD = 1472,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                     i_sys_clk,
   input  logic                     i_rst_n,
   input  logic [N_REQ-1:0]         i_req,
   output logic [N_REQ-1:0]         o_grant,
   input  logic [N_REQ-1:0]         i_wr_en,
   input  logic [N_REQ*ADDR_W-1:0]  i_wr_addr,
   input  logic [N_REQ*DATA_W-1:0]  i_wr_data,
   input  logic [N_REQ*16-1:0]      i_payload_len,
   input  logic [N_REQ-1:0]         i_fill_done,
   input  logic                     i_tx_busy,
   output logic                     o_ram_wr_en,
   output logic [ADDR_W-1:0]        o_ram_wr_addr,
   output logic [DATA_W-1:0]        o_ram_wr_data,
   output logic [15:0]              o_data_length,
   output logic [15:0]              o_total_length,
   output logic                     o_send_req,
   output logic [N_REQ-1:0]         o_pkt_done,
`ifdef UDP_TX_ARB_STATS_EN
   output logic [31:0]              o_pkt_cnt,
   output logic [15:0]              o_timeout_cnt,
`endif
   output logic                     o_err
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_SEND,
      S_WAIT_START,
      S_WAIT_DONE,
      S_RELEASE
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_idx;
   logic [CNT_W-1:0]   r_cnt;
   logic [N_REQ-1:0]   r_grant;
   logic [15:0]        r_data_length;
   logic [15:0]        r_total_length;
   logic               r_send_req;
   logic [N_REQ-1:0]   r_pkt_done;
   logic               r_err;
`ifdef UDP_TX_ARB_STATS_EN
   logic [31:0]        r_pkt_cnt;
   logic [15:0]        r_timeout_cnt;
`endif

   logic               w_any;
   logic [IDX_W-1:0]   w_pick;
   logic [15:0]        w_len;
   logic               w_len_bad;

   // Rotating priority search: first asserted request at or after the pointer.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      logic [IDX_W:0] v_j;
      w_any  = 1'b0;
      w_pick = '0;
      v_j    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         v_j = {1'b0, r_ptr} + (IDX_W+1)'(i);
         if (v_j >= (IDX_W+1)'(N_REQ)) v_j = v_j - (IDX_W+1)'(N_REQ);
         if (!w_any && i_req[v_j[IDX_W-1:0]]) begin
            w_any  = 1'b1;
            w_pick = v_j[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      o_ram_wr_en   = 1'b0;
      o_ram_wr_addr = '0;
      o_ram_wr_data = '0;
      if (r_state == S_FILL) begin
         o_ram_wr_en   = i_wr_en[r_idx];
         o_ram_wr_addr = i_wr_addr[int'(r_idx)*ADDR_W +: ADDR_W];
         o_ram_wr_data = i_wr_data[int'(r_idx)*DATA_W +: DATA_W];
      end
   end

   assign w_len     = i_payload_len[int'(r_idx)*16 +: 16];
   assign w_len_bad = (w_len == 16'd0) || (w_len > 16'(MAX_PAYLOAD));

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= S_IDLE;
         r_ptr          <= '0;
         r_idx          <= '0;
         r_cnt          <= '0;
         r_grant        <= '0;
         r_data_length  <= '0;
         r_total_length <= '0;
         r_send_req     <= 1'b0;
         r_pkt_done     <= '0;
         r_err          <= 1'b0;
`ifdef UDP_TX_ARB_STATS_EN
         r_pkt_cnt      <= '0;
         r_timeout_cnt  <= '0;
`endif
      end else begin
         r_send_req <= 1'b0;
         r_pkt_done <= '0;
         r_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_idx   <= w_pick;
                  r_grant <= N_REQ'(1) << w_pick;
                  r_state <= S_FILL;
               end
            end
            S_FILL: begin
               if (i_fill_done[r_idx]) begin
                  if (w_len_bad) begin
                     r_err      <= 1'b1;
                     r_pkt_done <= r_grant;
                     r_state    <= S_RELEASE;
                  end else begin
                     r_data_length  <= w_len + 16'd8;
                     r_total_length <= w_len + 16'd28;
                     r_send_req     <= 1'b1;
                     r_cnt          <= '0;
                     r_state        <= S_SEND;
                  end
               end
            end
            // The timeout window opens with the send-request cycle itself.
            S_SEND: begin
               r_cnt   <= r_cnt + 1'b1;
               r_state <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (i_tx_busy) begin
                  r_state <= S_WAIT_DONE;
               end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  r_err      <= 1'b1;
                  r_pkt_done <= r_grant;
                  r_state    <= S_RELEASE;
`ifdef UDP_TX_ARB_STATS_EN
                  if (r_timeout_cnt != '1) r_timeout_cnt <= r_timeout_cnt + 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (!i_tx_busy) begin
                  r_pkt_done <= r_grant;
                  r_state    <= S_RELEASE;
`ifdef UDP_TX_ARB_STATS_EN
                  if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 1'b1;
`endif
               end
            end
            S_RELEASE: begin
               r_grant <= '0;
               r_ptr   <= (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_grant        = r_grant;
   assign o_data_length  = r_data_length;
   assign o_total_length = r_total_length;
   assign o_send_req     = r_send_req;
   assign o_pkt_done     = r_pkt_done;
   assign o_err          = r_err;
`ifdef UDP_TX_ARB_STATS_EN
   assign o_pkt_cnt      = r_pkt_cnt;
   assign o_timeout_cnt  = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed self-checking bench for udp_tx_arbiter (default parameters, N_REQ=3).
module tb_udp_tx_arbiter;

   localparam int N      = 3;
   localparam int AW     = 9;
   localparam int DW     = 32;
   localparam int TO_CYC = 4096;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N-1:0]    grant;
   logic [N-1:0]    wr_en;
   logic [N*AW-1:0] wr_addr;
   logic [N*DW-1:0] wr_data;
   logic [N*16-1:0] payload_len;
   logic [N-1:0]    fill_done;
   logic            tx_busy;
   logic            ram_wr_en;
   logic [AW-1:0]   ram_wr_addr;
   logic [DW-1:0]   ram_wr_data;
   logic [15:0]     data_length;
   logic [15:0]     total_length;
   logic            send_req;
   logic [N-1:0]    pkt_done;
   logic            err;
`ifdef UDP_TX_ARB_STATS_EN
   logic [31:0]     pkt_cnt;
   logic [15:0]     timeout_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   int bad_wr  = 0;

   udp_tx_arbiter dut (
      .i_sys_clk      (clk),
      .i_rst_n        (rst_n),
      .i_req          (req),
      .o_grant        (grant),
      .i_wr_en        (wr_en),
      .i_wr_addr      (wr_addr),
      .i_wr_data      (wr_data),
      .i_payload_len  (payload_len),
      .i_fill_done    (fill_done),
      .i_tx_busy      (tx_busy),
      .o_ram_wr_en    (ram_wr_en),
      .o_ram_wr_addr  (ram_wr_addr),
      .o_ram_wr_data  (ram_wr_data),
      .o_data_length  (data_length),
      .o_total_length (total_length),
      .o_send_req     (send_req),
      .o_pkt_done     (pkt_done),
`ifdef UDP_TX_ARB_STATS_EN
      .o_pkt_cnt      (pkt_cnt),
      .o_timeout_cnt  (timeout_cnt),
`endif
      .o_err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wr_en) wr_cnt <= wr_cnt + 1;
      if (ram_wr_en && ram_wr_addr == 9'h1FF) bad_wr <= bad_wr + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input string tag, input logic [N-1:0] exp);
      for (int i = 0; i < 8; i++) begin
         if (grant != '0) break;
         tick();
      end
      check(tag, 32'(grant), 32'(exp));
   endtask

   // Ends the fill of producer k and walks the rest of its grant.
   task automatic finish_packet(input int k, input logic [15:0] len, input int busy_cyc,
                                input logic ok, input logic [15:0] exp_dl, input logic [15:0] exp_tl);
      payload_len[k*16 +: 16] = len;
      fill_done[k] = 1'b1;
      tick();
      fill_done = '0;
      if (ok) begin
         check("send_req_pulse", 32'(send_req), 32'd1);
         check("data_length", 32'(data_length), 32'(exp_dl));
         check("total_length", 32'(total_length), 32'(exp_tl));
         tick();
         check("send_req_single", 32'(send_req), 32'd0);
         tx_busy = 1'b1;
         tick();
         for (int i = 0; i < busy_cyc; i++) tick();
         check("no_done_while_busy", 32'(pkt_done), 32'd0);
         tx_busy = 1'b0;
         tick();
         check("pkt_done", 32'(pkt_done), 32'(1 << k));
         check("no_err_ok", 32'(err), 32'd0);
      end else begin
         check("err_pulse", 32'(err), 32'd1);
         check("pkt_done_err", 32'(pkt_done), 32'(1 << k));
         check("no_send_on_err", 32'(send_req), 32'd0);
      end
      tick();
      check("grant_released", 32'(grant), 32'd0);
      check("err_cleared", 32'(err), 32'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; req = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      payload_len = '0; fill_done = '0; tx_busy = 1'b0;
      #23;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_send_req", 32'(send_req), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_dl", 32'(data_length), 32'd0);
      check("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single producer 0, 20-byte payload, five writes at addr 0..4.
      req = 3'b001;
      tick();
      check("t1_grant_latency", 32'(grant), 32'b001);
      req = '0;
      wr_cnt = 0;
      for (int a = 0; a < 5; a++) begin
         wr_en[0] = 1'b1;
         wr_addr[0 +: AW] = AW'(a);
         wr_data[0 +: DW] = 32'hA000_0000 + 32'(a);
         #1;
         check("t1_wr_addr", 32'(ram_wr_addr), 32'(a));
         check("t1_wr_data", ram_wr_data, 32'hA000_0000 + 32'(a));
         tick();
      end
      wr_en = '0;
      check("t1_wr_count", 32'(wr_cnt), 32'd5);
      finish_packet(0, 16'd20, 200, 1'b1, 16'd28, 16'd48);

      // Producer 1 (pointer is now 1); reset asserted mid WAIT_DONE.
      req = 3'b010;
      wait_grant("t6_grant_p1", 3'b010);
      req = '0;
      payload_len[16 +: 16] = 16'd10;
      fill_done[1] = 1'b1;
      tick();
      fill_done = '0;
      check("t6_send", 32'(send_req), 32'd1);
      tick();
      tx_busy = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_grant", 32'(grant), 32'd0);
      check("t6_async_dl", 32'(data_length), 32'd0);
      check("t6_async_tl", 32'(total_length), 32'd0);
      check("t6_async_done", 32'(pkt_done), 32'd0);
      tick();
      tx_busy = 1'b0;
      rst_n = 1'b1;

      // All three request continuously: order 0,1,2,0.
      req = 3'b111;
      wait_grant("t2_grant0", 3'b001);
      finish_packet(0, 16'd100, 3, 1'b1, 16'd108, 16'd128);

      wait_grant("t2_grant1", 3'b010);
      wr_en = 3'b110;
      wr_addr[AW +: AW]   = 9'h010;
      wr_addr[2*AW +: AW] = 9'h1FF;
      wr_data[DW +: DW]   = 32'h1111_1111;
      wr_data[2*DW +: DW] = 32'h2222_2222;
      #1;
      check("t3_mux_en", 32'(ram_wr_en), 32'd1);
      check("t3_mux_addr", 32'(ram_wr_addr), 32'h010);
      check("t3_mux_data", ram_wr_data, 32'h1111_1111);
      tick();
      wr_en = 3'b100;
      #1;
      check("t3_other_ignored", 32'(ram_wr_en), 32'd0);
      fill_done = 3'b100;
      payload_len[32 +: 16] = 16'd50;
      tick();
      fill_done = '0;
      wr_en = '0;
      check("t3_foreign_done", 32'(send_req), 32'd0);
      check("t3_still_granted", 32'(grant), 32'b010);
      finish_packet(1, 16'd1, 2, 1'b1, 16'd9, 16'd29);

      wait_grant("t2_grant2", 3'b100);
      finish_packet(2, 16'd1473, 0, 1'b0, 16'd0, 16'd0);

      wait_grant("t2_grant0_again", 3'b001);
      finish_packet(0, 16'd1472, 1, 1'b1, 16'd1480, 16'd1500);
      check("t2_len_hold", 32'(data_length), 32'd1480);

      // Zero-length payload on producer 0 (pointer is 1, only producer 0 requests).
      req = 3'b001;
      wait_grant("t4_grant_zero", 3'b001);
      finish_packet(0, 16'd0, 0, 1'b0, 16'd0, 16'd0);
      check("t4_len_kept", 32'(total_length), 32'd1500);

      // Timeout: tx_busy never rises after the send request.
      req = 3'b010;
      wait_grant("t5_grant", 3'b010);
      req = '0;
      payload_len[16 +: 16] = 16'd4;
      fill_done[1] = 1'b1;
      tick();
      fill_done = '0;
      check("t5_send", 32'(send_req), 32'd1);
      n = 0;
      while (n < TO_CYC + 100) begin
         tick();
         n++;
         if (err) break;
      end
      check("t5_timeout_cycles", 32'(n), 32'(TO_CYC));
      check("t5_done_on_timeout", 32'(pkt_done), 32'b010);
      tick();
      check("t5_released", 32'(grant), 32'd0);
`ifdef UDP_TX_ARB_STATS_EN
      check("stats_timeout_cnt", 32'(timeout_cnt), 32'd1);
      check("stats_pkt_cnt", pkt_cnt, 32'd3);
`endif
      check("t3_no_write_1ff", 32'(bad_wr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit packet RAM write port and the UDP send-request input among N packet producers (ack/nack assembler, status reporter, boot banner writer).
- Grants one producer at a time, round-robin. Muxes its RAM writes through and derives the UDP and IP length fields from its payload length.
- Issues one send request, then holds the grant until the UDP transmitter has finished the frame.
- Sits between the producers and the tx RAM / udp block; everything runs in the gmii_rx_clk domain.

Parameters:
- N_REQ, 3, number of producers (2..8).
- ADDR_W, 9, tx RAM address width.
- DATA_W, 32, tx RAM data width.
- MAX_PAYLOAD, 1472, largest payload in bytes accepted.
- TIMEOUT_CYC, 4096, cycles allowed for i_tx_busy to rise after a send request.

Ports:
- i_sys_clk  in  1  system clock (gmii_rx_clk).
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  per-producer request, level, held until its grant.
- o_grant  out  N_REQ  one-hot grant.
- i_wr_en  in  N_REQ  per-producer RAM write enable.
- i_wr_addr  in  N_REQ*ADDR_W  packed producer addresses; producer k uses bits [k*ADDR_W +: ADDR_W].
- i_wr_data  in  N_REQ*DATA_W  packed producer write data.
- i_payload_len  in  N_REQ*16  packed payload byte counts, sampled on i_fill_done.
- i_fill_done  in  N_REQ  one-cycle pulse: granted producer finished writing.
- i_tx_busy  in  1  UDP transmitter not idle.
- o_ram_wr_en  out  1  to tx RAM wea.
- o_ram_wr_addr  out  ADDR_W  to tx RAM addra.
- o_ram_wr_data  out  DATA_W  to tx RAM dina.
- o_data_length  out  16  UDP length (payload+8).
- o_total_length  out  16  IP total length (payload+28).
- o_send_req  out  1  one-cycle send request to the udp block.
- o_pkt_done  out  N_REQ  one-cycle completion pulse to the granted producer.
- o_err  out  1  one-cycle pulse on oversize length or timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
- Reset has asynchronous assertion; logic assumes synchronous deassertion upstream.
- IDLE:
  - Pick the first asserted i_req, starting at the pointer and wrapping modulo N_REQ.
  - Register the one-hot o_grant; o_grant is visible the cycle after i_req is seen.
  - Go to FILL. No requests: stay in IDLE.
- FILL:
  - o_ram_wr_en/addr/data are a combinational mux of the granted producer's inputs (zero latency).
  - Writes from non-granted producers are ignored.
  - On the granted i_fill_done, sample the payload length L:
    - L > MAX_PAYLOAD or L == 0: pulse o_err, pulse o_pkt_done for that producer, go to RELEASE.
    - Otherwise: register o_data_length = L+8 and o_total_length = L+28 (16-bit, no overflow because of the bound) and go to SEND.
  - i_fill_done from a non-granted producer is ignored.
- SEND: o_send_req=1 for exactly one cycle; go to WAIT_START.
- WAIT_START:
  - i_tx_busy=1: go to WAIT_DONE.
  - A cycle counter reaches TIMEOUT_CYC-1: pulse o_err and o_pkt_done, go to RELEASE.
- WAIT_DONE: i_tx_busy=0: pulse o_pkt_done, go to RELEASE.
- RELEASE:
  - o_grant=0; pointer = granted index+1, wrapping at N_REQ; go to IDLE.
  - Minimum gap between grants: 1 cycle.
- Length outputs hold their last valid value until the next SEND. They are never changed while i_tx_busy=1.
- A requester that drops i_req mid-grant does not abort the grant; only i_fill_done or a timeout ends it.
- i_tx_busy already high in IDLE or FILL is ignored; detection of busy starts after o_send_req.

Optional Feature:
- Macro UDP_TX_ARB_STATS_EN.
- When defined, adds output ports:
  - o_pkt_cnt [31:0]: increments on each successful o_pkt_done.
  - o_timeout_cnt [15:0]: increments on each timeout.
  - Both counters saturate and are reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single producer 0, 20-byte payload, writes addr 0..4 then i_fill_done → RAM sees 5 writes at addr 0..4; o_data_length=28, o_total_length=48; one o_send_req pulse. Hold i_tx_busy for 200 cycles → o_pkt_done[0] one cycle after busy falls.
- i_req=3'b111 held continuously, each producer completes → grant order 0,1,2,0. No grant overlaps an active i_tx_busy.
- Producer 1 granted; producer 2 drives i_wr_en=1 with addr 0x1FF → o_ram_wr_en follows producer 1 only; addr 0x1FF is never written.
- Payload 1473 → o_err pulse, no o_send_req, o_pkt_done[k] pulse, next requester granted.
- i_tx_busy never rises after o_send_req → o_err exactly TIMEOUT_CYC cycles later, grant released. With UDP_TX_ARB_STATS_EN, o_timeout_cnt=1.
- i_rst_n low during WAIT_DONE → all outputs 0 asynchronously; after release, IDLE with pointer 0 and producer 0 granted first.
